// File: rtl/vector_lane_permuter.sv
// One-stage registered lane permuter with valid/ready handshake on both sides.
// Also counts accepted input words.
module vector_lane_permuter #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16,
  localparam int DW    = LANES * LANE_W,
  localparam int RW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [1:0]       mode,
  input  logic [RW-1:0]    rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Rotation is a constant-indexed mux per lane, so non-power-of-two LANES wraps correctly.
  function automatic logic [DW-1:0] permute(input logic [DW-1:0] d,
                                            input logic [1:0]    m,
                                            input logic [RW-1:0] r);
    logic [DW-1:0] res;
    res = d;
    case (m)
      2'd1: begin
        for (int k = 0; k < LANES; k++)
          res[k*LANE_W +: LANE_W] = d[(LANES-1-k)*LANE_W +: LANE_W];
      end
      2'd2: begin
        for (int k = 0; k < LANES; k++)
          for (int s = 0; s < (1 << RW); s++)
            if (r == RW'(s))
              res[k*LANE_W +: LANE_W] = d[((k + LANES - (s % LANES)) % LANES)*LANE_W +: LANE_W];
      end
      2'd3: begin
        for (int b = 0; b < DW; b++)
          res[b] = d[DW-1-b];
      end
      default: res = d;
    endcase
    return res;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = permute(in_data, mode, rot);
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_vector_lane_permuter.sv
// Directed bench for vector_lane_permuter: behavioural model checked every cycle,
// plus literal expectations taken straight from the permutation rules.
module tb_vector_lane_permuter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  mode;
  logic [1:0]  rot;
  logic        out_ready;
  logic [2:0]  rot_w;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] xfer_cnt;

  logic        in_ready_c, out_valid_c;
  logic [31:0] out_data_c;
  logic [3:0]  xfer_cnt_c;

  logic        in_ready_w, out_valid_w;
  logic [31:0] out_data_w;
  logic [15:0] xfer_cnt_w;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  logic        m_valid;
  logic [31:0] m_data;
  int          m_cnt;

  assign rot_w = {1'b0, rot};

  always #5 clk = ~clk;

  vector_lane_permuter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .rot(rot), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt));

  vector_lane_permuter #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .mode(mode), .rot(rot), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .xfer_cnt(xfer_cnt_c));

  vector_lane_permuter #(.LANES(8), .LANE_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .mode(mode), .rot(rot_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .xfer_cnt(xfer_cnt_w));

  // Reference permutation for 4 lanes of 8 bits, using byte/shift arithmetic.
  function automatic logic [31:0] model_perm(input logic [31:0] d, input logic [1:0] m,
                                             input logic [1:0] r);
    logic [63:0] dbl;
    logic [31:0] res;
    case (m)
      2'd0: res = d;
      2'd1: res = {d[7:0], d[15:8], d[23:16], d[31:24]};
      2'd2: begin
        dbl = {d, d} << (int'(r) * 8);
        res = dbl[63:32];
      end
      default: begin
        res = '0;
        for (int b = 0; b < 32; b++) res[31-b] = d[b];
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_cnt   <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_data  <= model_perm(in_data, mode, rot);
      m_cnt   <= m_cnt + 1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      chk("cyc_out_data", 64'(out_data), 64'(m_data));
      chk("cyc_xfer_cnt", 64'(xfer_cnt), 64'(m_cnt[15:0]));
      chk("cyc_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("cyc_cnt4", 64'(xfer_cnt_c), 64'(m_cnt[3:0]));
      chk("cyc_valid_w", 64'(out_valid_w), 64'(m_valid));
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] m,
                      input logic [1:0] r, input logic ordy);
    in_valid  = v;
    in_data   = d;
    mode      = m;
    rot       = r;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] V0 = 32'h13E589A8;
  localparam logic [31:0] V1 = 32'hB1F05663;
  localparam logic [31:0] V2 = 32'hF207CB89;
  localparam logic [31:0] V3 = 32'h00F3D304;

  initial begin
    logic [31:0] vecs [4];
    logic [31:0] revs [4];
    vecs = '{V0, V1, V2, V3};
    revs = '{32'hA889E513, 32'h6356F0B1, 32'h89CB07F2, 32'h04D3F300};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; rot = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    step(1'b1, V0, 2'd1, 2'd0, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'hA889E513);
    chk("t1_cnt", 64'(xfer_cnt), 64'd1);
    chk("t6_wide_rev", 64'(out_data_w), 64'h8A985E31);

    step(1'b1, V0, 2'd2, 2'd1, 1'b1);
    chk("t2_rot1", 64'(out_data), 64'hE589A813);
    step(1'b1, V0, 2'd2, 2'd3, 1'b1);
    chk("t2_rot3", 64'(out_data), 64'hA813E589);
    step(1'b1, V0, 2'd2, 2'd0, 1'b1);
    chk("t2_rot0", 64'(out_data), 64'h13E589A8);
    step(1'b1, V0, 2'd3, 2'd0, 1'b1);
    chk("t2_bitrev", 64'(out_data), 64'h1591A7C8);
    step(1'b1, V1, 2'd0, 2'd0, 1'b1);
    chk("t2_pass", 64'(out_data), 64'hB1F05663);

    step(1'b1, V2, 2'd1, 2'd0, 1'b1);
    chk("t3_first", 64'(out_data), 64'h89CB07F2);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, V3, 2'((i % 2) ? 3 : 1), 2'(i), 1'b0);
      chk("t3_hold_data", 64'(out_data), 64'h89CB07F2);
      chk("t3_hold_ready", 64'(in_ready), 64'd0);
      chk("t3_hold_cnt", 64'(xfer_cnt), 64'd7);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
    end
    step(1'b1, V3, 2'd1, 2'd0, 1'b1);
    chk("t3_release", 64'(out_data), 64'h04D3F300);
    chk("t3_rel_cnt", 64'(xfer_cnt), 64'd8);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vecs[i], 2'd1, 2'd0, 1'b1);
      chk("t4_stream", 64'(out_data), 64'(revs[i]));
    end
    chk("t4_cnt", 64'(xfer_cnt), 64'd4);

    step(1'b0, V0, 2'd0, 2'd0, 1'b0);
    chk("t5_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_cnt", 64'(xfer_cnt), 64'd0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) step(1'b1, vecs[i % 4], 2'(i % 4), 2'(i), 1'b1);
    chk("t6_cnt4_wrap", 64'(xfer_cnt_c), 64'd1);
    chk("t6_cnt16", 64'(xfer_cnt), 64'd17);

    step(1'b0, V0, 2'd0, 2'd0, 1'b1);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data_kept", 64'(out_data), 64'(model_perm(V0, 2'd0, 2'd0)));
    step(1'b0, V0, 2'd0, 2'd0, 1'b1);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
